// File: rtl/leitor_memoria_if.sv
// Bus bundle for the burst memory reader: command, RAM read port and output stream.
// master is the reader side; slave is the requester/RAM/consumer side.
interface leitor_memoria_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 16
);
   logic              start;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W:0]   count;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] mem_address;
   logic              mem_read;
   logic [DATA_W-1:0] mem_data;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (
      input  start, base, count, mem_data, out_ready,
      output busy, done, mem_address, mem_read, out_data, out_valid
   );

   modport slave (
      output start, base, count, mem_data, out_ready,
      input  busy, done, mem_address, mem_read, out_data, out_valid
   );
endinterface

// File: rtl/leitor_memoria.sv
// Burst reader: streams count words from a 1-cycle-latency RAM starting at base
// into a 2-entry output FIFO, issuing reads only when a FIFO slot is guaranteed.
module leitor_memoria #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   leitor_memoria_if.master     bus
);
   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t                       state_q, state_d;
   logic [ADDR_W-1:0]            addr_q, addr_d;
   logic [ADDR_W:0]              rem_q, rem_d;
   logic                         infl_q;
   logic                         done_q, done_d;
   logic [1:0][DATA_W-1:0]       fifo_q;
   logic                         rd_ptr_q, wr_ptr_q;
   logic [1:0]                   occ_q, occ_d;
   logic                         push, pop, rd;

   // RAM data lands one cycle after each read strobe
   assign push  = infl_q;
   assign pop   = (occ_q != 2'd0) && bus.out_ready;
   assign occ_d = occ_q + {1'b0, push} - {1'b0, pop};

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      rd      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.count == '0) begin
                  done_d = 1'b1;
               end else begin
                  addr_d  = bus.base;
                  rem_d   = bus.count;
                  state_d = READ;
               end
            end
         end
         READ: begin
            // credit: words held plus in flight, less this cycle's pop, must leave a slot
            rd = ({1'b0, occ_q} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop});
            if (rd) begin
               addr_d = addr_q + ADDR_W'(1);
               rem_d  = rem_q - (ADDR_W+1)'(1);
               if (rem_q == (ADDR_W+1)'(1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!infl_q && occ_d == 2'd0) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         rem_q    <= '0;
         infl_q   <= 1'b0;
         done_q   <= 1'b0;
         fifo_q   <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         infl_q  <= rd;
         done_q  <= done_d;
         occ_q   <= occ_d;
         if (push) begin
            fifo_q[wr_ptr_q] <= bus.mem_data;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
   end

   assign bus.busy        = (state_q != IDLE);
   assign bus.done        = done_q;
   assign bus.mem_address = addr_q;
   assign bus.mem_read    = rd;
   assign bus.out_valid   = (occ_q != 2'd0);
   assign bus.out_data    = fifo_q[rd_ptr_q];
endmodule

// File: tb/tb_leitor_memoria.sv
// Directed bench for leitor_memoria: RAM model M[a]=a, posedge monitor logs
// reads/words/done with cycle stamps, linear steps check against hand values.
module tb_leitor_memoria;
   localparam int AW = 14;
   localparam int DW = 16;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0, errors = 0;
   int   cyc = 0, donecnt = 0, donec = 0;
   int   rda[$], rdc[$], outd[$], outc[$];
   int   rs, os, d0, d1, n;

   leitor_memoria_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   leitor_memoria #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n)          bus.mem_data <= '0;
      else if (bus.mem_read) bus.mem_data <= DW'(bus.mem_address);
   end

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (bus.mem_read) begin
         rda.push_back(int'(bus.mem_address));
         rdc.push_back(cyc);
      end
      if (bus.out_valid && bus.out_ready) begin
         outd.push_back(int'(bus.out_data));
         outc.push_back(cyc);
      end
      if (bus.done) begin
         donecnt <= donecnt + 1;
         donec   <= cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      rs = rda.size();
      os = outd.size();
      d0 = donecnt;
   endtask

   task automatic go(input int b, input int c);
      bus.base  = AW'(b);
      bus.count = (AW+1)'(c);
      bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int maxc);
      int k;
      k = 0;
      while (donecnt == d0 && k < maxc) begin
         @(negedge clock);
         k++;
      end
      chk("done_seen", donecnt != d0, 1);
      repeat (3) @(negedge clock);
      chk("done_once", donecnt - d0, 1);
   endtask

   task automatic check_stream(input string tag, input int b, input int cnt);
      chk({tag, "_nreads"}, rda.size() - rs, cnt);
      chk({tag, "_nwords"}, outd.size() - os, cnt);
      for (int i = 0; i < cnt; i++) begin
         if (rda.size() > rs + i)  chk({tag, "_addr"}, rda[rs+i], (b + i) & 'h3FFF);
         if (outd.size() > os + i) chk({tag, "_word"}, outd[os+i], (b + i) & 'h3FFF);
      end
   endtask

   task automatic check_reset_outs(input string tag);
      chk({tag, "_busy"},  bus.busy, 0);
      chk({tag, "_done"},  bus.done, 0);
      chk({tag, "_mrd"},   bus.mem_read, 0);
      chk({tag, "_maddr"}, bus.mem_address, 0);
      chk({tag, "_oval"},  bus.out_valid, 0);
      chk({tag, "_odata"}, bus.out_data, 0);
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.base      = '0;
      bus.count     = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clock);
      check_reset_outs("rst");
      reset_n = 1'b1;

      // full rate, start on the first edge after reset release
      bus.out_ready = 1'b1;
      snap();
      go('h10, 4);
      wait_done(40);
      check_stream("full", 'h10, 4);
      if (rdc.size() >= rs + 4)  chk("full_rd_consec", rdc[rs+3] - rdc[rs], 3);
      if (outc.size() >= os + 4) begin
         chk("full_out_consec", outc[os+3] - outc[os], 3);
         chk("full_done_after", donec - outc[os+3], 1);
      end

      // backpressure: 10 stalled cycles including the start cycle
      bus.out_ready = 1'b0;
      snap();
      go('h100, 5);
      repeat (4) @(negedge clock);
      chk("bp_hold_mid", bus.out_data, 'h100);
      repeat (5) @(negedge clock);
      chk("bp_reads_stall", rda.size() - rs, 2);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_hold_end", bus.out_data, 'h100);
      chk("bp_busy", bus.busy, 1);
      bus.out_ready = 1'b1;
      wait_done(40);
      check_stream("bp", 'h100, 5);

      // address wrap
      snap();
      go('h3FFE, 4);
      wait_done(40);
      check_stream("wrap", 'h3FFE, 4);

      // zero count
      snap();
      go(0, 0);
      chk("zero_done", bus.done, 1);
      chk("zero_busy", bus.busy, 0);
      chk("zero_mrd", bus.mem_read, 0);
      repeat (3) @(negedge clock);
      chk("zero_done_low", bus.done, 0);
      chk("zero_nreads", rda.size() - rs, 0);
      chk("zero_done_cnt", donecnt - d0, 1);

      // start while busy is ignored
      snap();
      go('h200, 3);
      bus.base  = AW'('h300);
      bus.count = (AW+1)'(7);
      bus.start = 1'b1;
      repeat (2) @(negedge clock);
      bus.start = 1'b0;
      wait_done(40);
      check_stream("busy_start", 'h200, 3);
      chk("busy_start_idle", bus.busy, 0);

      // mid-burst reset after 2 of 6 words
      snap();
      go('h40, 6);
      n = 0;
      while (outd.size() - os < 2 && n < 30) begin
         @(negedge clock);
         n++;
      end
      chk("mid_two_words", outd.size() - os, 2);
      reset_n = 1'b0;
      #1;
      check_reset_outs("mid");
      @(negedge clock);
      reset_n = 1'b1;
      d1 = donecnt;
      repeat (5) @(negedge clock);
      chk("mid_no_done", donecnt - d0, 0);
      chk("mid_idle", bus.busy, 0);
      snap();
      go('h80, 3);
      wait_done(40);
      check_stream("post_rst", 'h80, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
